// File: rtl/mem_if_pkg.sv
// Shared data-memory interface definitions: opcodes, FSM state encoding and
// the legality check applied to every incoming load/store request.
package mem_if_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int ADDR_BITS_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // A request is legal only for LW/SW with no address bits above the decoded range.
  function automatic logic is_legal(input logic [5:0] opc, input logic [31:0] addr,
                                    input int abits);
    return ((opc == OP_LW) || (opc == OP_SW)) && ((addr >> abits) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_strobe_timer.sv
// Counts the cycles a memory strobe stays high; 'last' marks the final
// strobe cycle of an access.
module mem_strobe_timer #(
  parameter int ACC_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(ACC_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(ACC_LAT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: accepts one load/store per
// transaction, drives registered strobes/address/data and captures loads into LMD.
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int ACC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op_opcode,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic [5:0]  opcode,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        MemR,
  output logic        MemW,
  input  logic [31:0] readData,
  output logic [31:0] LMD,
  output logic        done,
  output logic        err
);

  state_t state, state_next;
  logic   accept;
  logic   legal;
  logic   last;

  assign op_ready = (state == IDLE) && !rst;
  assign accept   = op_valid && op_ready;
  assign legal    = is_legal(op_opcode, op_addr, ADDR_BITS);

  mem_strobe_timer #(.ACC_LAT(ACC_LAT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == SETUP),
    .en   (state == STROBE),
    .last (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = legal ? SETUP : DONE;
      SETUP:   state_next = STROBE;
      STROBE:  if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and done/err are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opcode    <= '0;
      address   <= '0;
      writeData <= '0;
      MemR      <= 1'b0;
      MemW      <= 1'b0;
      LMD       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        opcode    <= op_opcode;
        address   <= op_addr;
        writeData <= op_wdata;
      end
      MemR <= (state_next == STROBE) && (opcode == OP_LW);
      MemW <= (state_next == STROBE) && (opcode == OP_SW);
      done <= (state_next == DONE);
      err  <= (state == IDLE) && (state_next == DONE);
      if ((state == STROBE) && last && (opcode == OP_LW)) begin
        LMD <= readData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table-driven load/store/error
// vectors on an ACC_LAT=1 instance plus hand sequences for multi-cycle cases.
module tb_mem_access_ctrl;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_valid3;
  logic [5:0]  op_opcode;
  logic [31:0] op_addr, op_wdata;

  logic        op_ready, MemR, MemW, done, err;
  logic [5:0]  opcode;
  logic [31:0] address, writeData, readData, LMD;

  logic        op_ready3, MemR3, MemW3, done3, err3;
  logic [5:0]  opcode3;
  logic [31:0] address3, writeData3, readData3, LMD3;

  logic [31:0] mem [1024];
  int testCount = 0;
  int failCount = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_BITS(10), .ACC_LAT(1)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_opcode(op_opcode), .op_addr(op_addr), .op_wdata(op_wdata),
    .opcode(opcode), .address(address), .writeData(writeData),
    .MemR(MemR), .MemW(MemW), .readData(readData), .LMD(LMD),
    .done(done), .err(err)
  );

  mem_access_ctrl #(.ADDR_BITS(10), .ACC_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .op_valid(op_valid3), .op_ready(op_ready3),
    .op_opcode(op_opcode), .op_addr(op_addr), .op_wdata(op_wdata),
    .opcode(opcode3), .address(address3), .writeData(writeData3),
    .MemR(MemR3), .MemW(MemW3), .readData(readData3), .LMD(LMD3),
    .done(done3), .err(err3)
  );

  // Simple data memory for the ACC_LAT=1 instance; a fixed pattern for the other.
  assign readData  = mem[address[9:0]];
  assign readData3 = address3 ^ 32'hA5A50000;

  always @(posedge clk) begin
    if (MemW) mem[address[9:0]] <= writeData;
  end

  always @(negedge clk) begin
    if ((MemR && MemW) || (MemR3 && MemW3)) overlap++;
  end

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expLmd;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] opc, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output int rdFirst, output int rdCnt,
                               output int wrFirst, output int wrCnt,
                               output int doneCyc, output int doneCnt,
                               output int errAtDone, output int readyCyc,
                               output int addrBad);
    int w;
    rdFirst = -1; rdCnt = 0; wrFirst = -1; wrCnt = 0;
    doneCyc = -1; doneCnt = 0; errAtDone = -1; readyCyc = -1; addrBad = 0;
    @(negedge clk);
    w = 0;
    while (!op_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) checkOutput("ready_timeout", 32'(op_ready), 32'd1);
    op_opcode = opc;
    op_addr   = addr;
    op_wdata  = wdata;
    op_valid  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) op_valid = 1'b0;
      if (MemR) begin
        if (rdFirst < 0) rdFirst = c;
        rdCnt++;
      end
      if (MemW) begin
        if (wrFirst < 0) wrFirst = c;
        wrCnt++;
      end
      if (doneCnt == 0 && (address !== addr || opcode !== opc || writeData !== wdata)) addrBad++;
      if (done) begin
        doneCnt++;
        doneCyc = c;
        errAtDone = int'(err);
      end
      if (op_ready && readyCyc < 0) readyCyc = c;
    end
  endtask

  initial begin
    int rdFirst, rdCnt, wrFirst, wrCnt, doneCyc, doneCnt, errAtDone, readyCyc, addrBad;
    int doneSeen;
    logic isLd, isSt;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;

    vecs[0] = '{OP_LW, 32'd5,          32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{OP_SW, 32'd1023,       32'h12345678, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{OP_LW, 32'd1023,       32'h0,        1'b0, 32'h12345678};
    vecs[3] = '{OP_LW, 32'h400,        32'h0,        1'b1, 32'h12345678};
    vecs[4] = '{6'b000000, 32'd5,      32'h0,        1'b1, 32'h12345678};
    vecs[5] = '{OP_SW, 32'h80000000,   32'h55555555, 1'b1, 32'h12345678};
    vecs[6] = '{OP_SW, 32'd0,          32'hCAFEF00D, 1'b0, 32'h12345678};
    vecs[7] = '{OP_LW, 32'd0,          32'h0,        1'b0, 32'hCAFEF00D};

    rst = 1'b1; op_valid = 1'b0; op_valid3 = 1'b0;
    op_opcode = 6'h0; op_addr = 32'h0; op_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_op_ready", 32'(op_ready), 32'd0);
    checkOutput("reset_MemR", 32'(MemR), 32'd0);
    checkOutput("reset_MemW", 32'(MemW), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_address", address, 32'd0);
    checkOutput("reset_writeData", writeData, 32'd0);
    checkOutput("reset_LMD", LMD, 32'd0);
    checkOutput("reset_opcode", 32'(opcode), 32'd0);
    rst = 1'b0;
    #1 checkOutput("ready_after_reset", 32'(op_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].opc, vecs[i].addr, vecs[i].wdata,
                    rdFirst, rdCnt, wrFirst, wrCnt, doneCyc, doneCnt, errAtDone, readyCyc, addrBad);
      isLd = !vecs[i].expErr && (vecs[i].opc == OP_LW);
      isSt = !vecs[i].expErr && (vecs[i].opc == OP_SW);
      checkOutput($sformatf("v%0d_err", i), 32'(errAtDone), 32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d_done_cycle", i), 32'(doneCyc), vecs[i].expErr ? 32'd1 : 32'd3);
      checkOutput($sformatf("v%0d_done_count", i), 32'(doneCnt), 32'd1);
      checkOutput($sformatf("v%0d_ready_cycle", i), 32'(readyCyc), vecs[i].expErr ? 32'd2 : 32'd4);
      checkOutput($sformatf("v%0d_MemR_first", i), 32'(rdFirst), isLd ? 32'd2 : 32'hFFFFFFFF);
      checkOutput($sformatf("v%0d_MemR_cycles", i), 32'(rdCnt), isLd ? 32'd1 : 32'd0);
      checkOutput($sformatf("v%0d_MemW_first", i), 32'(wrFirst), isSt ? 32'd2 : 32'hFFFFFFFF);
      checkOutput($sformatf("v%0d_MemW_cycles", i), 32'(wrCnt), isSt ? 32'd1 : 32'd0);
      checkOutput($sformatf("v%0d_LMD", i), LMD, vecs[i].expLmd);
      checkOutput($sformatf("v%0d_fields_stable", i), 32'(addrBad), 32'd0);
    end
    checkOutput("mem1023_written", mem[1023], 32'h12345678);

    // Back-pressure: valid held through the first op; the same request is taken again.
    @(negedge clk);
    op_opcode = OP_LW; op_addr = 32'd5; op_wdata = 32'h0; op_valid = 1'b1;
    doneCnt = 0; doneSeen = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) checkOutput("bp_ready_c1", 32'(op_ready), 32'd0);
      if (c == 4) checkOutput("bp_ready_c4", 32'(op_ready), 32'd1);
      if (c == 5) begin
        checkOutput("bp_ready_c5", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
      end
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) checkOutput("bp_done1_cycle", 32'(c), 32'd3);
        if (doneCnt == 2) checkOutput("bp_done2_cycle", 32'(c), 32'd7);
      end
    end
    checkOutput("bp_done_pulses", 32'(doneCnt), 32'd2);
    checkOutput("bp_LMD", LMD, 32'hDEADBEEF);

    // ACC_LAT=3: load then store on the second instance.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op_opcode = (k == 0) ? OP_LW : OP_SW;
      op_addr   = (k == 0) ? 32'd7 : 32'd9;
      op_wdata  = 32'h0BADF00D;
      op_valid3 = 1'b1;
      rdFirst = -1; rdCnt = 0; wrCnt = 0; doneCyc = -1; readyCyc = -1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) op_valid3 = 1'b0;
        if (MemR3) begin
          if (rdFirst < 0) rdFirst = c;
          rdCnt++;
        end
        if (MemW3) wrCnt++;
        if (done3) doneCyc = c;
        if (op_ready3 && readyCyc < 0) readyCyc = c;
      end
      checkOutput($sformatf("lat3_%0d_MemR_cycles", k), 32'(rdCnt), (k == 0) ? 32'd3 : 32'd0);
      checkOutput($sformatf("lat3_%0d_MemW_cycles", k), 32'(wrCnt), (k == 0) ? 32'd0 : 32'd3);
      checkOutput($sformatf("lat3_%0d_done_cycle", k), 32'(doneCyc), 32'd5);
      checkOutput($sformatf("lat3_%0d_ready_cycle", k), 32'(readyCyc), 32'd6);
      checkOutput($sformatf("lat3_%0d_LMD", k), LMD3, 32'hA5A50007);
    end
    checkOutput("lat3_MemR_first", 32'(rdFirst), 32'hFFFFFFFF);

    // Reset during the strobe of a store: strobe drops at once, no done afterwards.
    @(negedge clk);
    op_opcode = OP_SW; op_addr = 32'd10; op_wdata = 32'h11; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_MemW_before", 32'(MemW), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_MemW_dropped", 32'(MemW), 32'd0);
    checkOutput("rst_mid_ready_low", 32'(op_ready), 32'd0);
    checkOutput("rst_mid_address_clear", address, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("rst_mid_ready_after", 32'(op_ready), 32'd1);
    doneCnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("rst_mid_no_done", 32'(doneCnt), 32'd0);
    checkOutput("strobe_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
